// File: rtl/reg_async.sv
// Register file with 16 x DATA_W registers (R15 doubles as PC) and a separate CSPR.
// State advances only on clk edges where the async handshake presents ack=1.
module reg_async #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              ack,
    input  logic [ADDR_W-1:0] write_address_1,
    input  logic [ADDR_W-1:0] write_address_2,
    input  logic [ADDR_W-1:0] write_address_3,
    input  logic [ADDR_W-1:0] write_address_4,
    input  logic [DATA_W-1:0] write_data_1,
    input  logic [DATA_W-1:0] write_data_2,
    input  logic [DATA_W-1:0] write_data_3,
    input  logic [DATA_W-1:0] write_data_4,
    input  logic              write_enable_1,
    input  logic              write_enable_2,
    input  logic              write_enable_3,
    input  logic              write_enable_4,
    input  logic [ADDR_W-1:0] in_address_1,
    input  logic [ADDR_W-1:0] in_address_2,
    input  logic [ADDR_W-1:0] in_address_3,
    input  logic              read_enable_1,
    input  logic              read_enable_2,
    input  logic              read_enable_3,
    input  logic [ADDR_W-1:0] in_address_4,
    input  logic [DATA_W-1:0] pc_update,
    input  logic              pc_write,
    input  logic [DATA_W-1:0] cspr_update,
    input  logic              cspr_write,
    output logic [DATA_W-1:0] out_data_1,
    output logic [DATA_W-1:0] out_data_2,
    output logic [DATA_W-1:0] out_data_3,
    output logic [DATA_W-1:0] out_data_4,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] cspr
);

    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int NUM_WR   = 4;
    localparam int NUM_RD   = 3;
    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(NUM_REGS - 1);

    logic [DATA_W-1:0] regs_reg  [NUM_REGS];
    logic [DATA_W-1:0] regs_next [NUM_REGS];
    logic [DATA_W-1:0] cspr_reg;
    logic [DATA_W-1:0] cspr_next;

    logic [ADDR_W-1:0] wr_addr [NUM_WR];
    logic [DATA_W-1:0] wr_data [NUM_WR];
    logic [NUM_WR-1:0] wr_en;
    logic [ADDR_W-1:0] rd_addr [NUM_RD];
    logic [NUM_RD-1:0] rd_en;
    logic [DATA_W-1:0] rd_data [NUM_RD];

    // req is part of the handshake but ack alone qualifies a commit.
    logic unused_req;
    assign unused_req = req;

    assign wr_addr[0] = write_address_1;
    assign wr_addr[1] = write_address_2;
    assign wr_addr[2] = write_address_3;
    assign wr_addr[3] = write_address_4;
    assign wr_data[0] = write_data_1;
    assign wr_data[1] = write_data_2;
    assign wr_data[2] = write_data_3;
    assign wr_data[3] = write_data_4;
    assign wr_en      = {write_enable_4, write_enable_3, write_enable_2, write_enable_1};

    assign rd_addr[0] = in_address_1;
    assign rd_addr[1] = in_address_2;
    assign rd_addr[2] = in_address_3;
    assign rd_en      = {read_enable_3, read_enable_2, read_enable_1};

    // Ports applied in ascending order so the highest-numbered port wins; PC load last of all.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            regs_next[r] = regs_reg[r];
        end
        cspr_next = cspr_reg;
        if (ack) begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_en[p]) begin
                    regs_next[wr_addr[p]] = wr_data[p];
                end
            end
            if (pc_write) begin
                regs_next[PC_ADDR] = pc_update;
            end
            if (cspr_write) begin
                cspr_next = cspr_update;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_reg[r] <= '0;
            end
            cspr_reg <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_reg[r] <= regs_next[r];
            end
            cspr_reg <= cspr_next;
        end
    end

    // Read ports sample the pre-edge array, so a same-edge write is never bypassed.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [DATA_W-1:0] data_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_reg <= '0;
                end else if (ack && rd_en[gi]) begin
                    data_reg <= regs_reg[rd_addr[gi]];
                end
            end

            assign rd_data[gi] = data_reg;
        end
    endgenerate

    assign out_data_1 = rd_data[0];
    assign out_data_2 = rd_data[1];
    assign out_data_3 = rd_data[2];
    assign out_data_4 = regs_reg[in_address_4];
    assign pc         = regs_reg[PC_ADDR];
    assign cspr       = cspr_reg;

endmodule

// File: tb/tb_reg_async.sv
// Self-checking bench for reg_async: directed scenarios followed by randomized traffic,
// all checked against an array-based reference model of the register file.
module tb_reg_async;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        ack;
    logic [3:0]  wa [4];
    logic [31:0] wd [4];
    logic [3:0]  we;
    logic [3:0]  ra [3];
    logic [2:0]  re;
    logic [3:0]  dbg_addr;
    logic [31:0] pc_update;
    logic        pc_write;
    logic [31:0] cspr_update;
    logic        cspr_write;
    logic [31:0] out_data_1, out_data_2, out_data_3, out_data_4, pc, cspr;

    logic [31:0] model_regs [16];
    logic [31:0] model_cspr;
    logic [31:0] model_out [3];

    int n_compared;
    int n_mismatched;
    int n_step;

    reg_async #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
        .write_address_1(wa[0]), .write_address_2(wa[1]),
        .write_address_3(wa[2]), .write_address_4(wa[3]),
        .write_data_1(wd[0]), .write_data_2(wd[1]),
        .write_data_3(wd[2]), .write_data_4(wd[3]),
        .write_enable_1(we[0]), .write_enable_2(we[1]),
        .write_enable_3(we[2]), .write_enable_4(we[3]),
        .in_address_1(ra[0]), .in_address_2(ra[1]), .in_address_3(ra[2]),
        .read_enable_1(re[0]), .read_enable_2(re[1]), .read_enable_3(re[2]),
        .in_address_4(dbg_addr),
        .pc_update(pc_update), .pc_write(pc_write),
        .cspr_update(cspr_update), .cspr_write(cspr_write),
        .out_data_1(out_data_1), .out_data_2(out_data_2), .out_data_3(out_data_3),
        .out_data_4(out_data_4), .pc(pc), .cspr(cspr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        for (int i = 0; i < 4; i++) begin
            wa[i] = 4'd0;
            wd[i] = 32'd0;
        end
        for (int i = 0; i < 3; i++) ra[i] = 4'd0;
        we = 4'b0; re = 3'b0;
        pc_write = 1'b0; pc_update = 32'd0;
        cspr_write = 1'b0; cspr_update = 32'd0;
        req = 1'b1; ack = 1'b1;
    endtask

    function automatic void model_reset();
        for (int r = 0; r < 16; r++) model_regs[r] = 32'd0;
        model_cspr = 32'd0;
        for (int n = 0; n < 3; n++) model_out[n] = 32'd0;
    endfunction

    // One commit: reads see the old array, then writes in rising priority, PC load on top.
    function automatic void model_commit();
        logic [31:0] snap [16];
        snap = model_regs;
        for (int n = 0; n < 3; n++)
            if (re[n]) model_out[n] = snap[ra[n]];
        for (int p = 0; p < 4; p++)
            if (we[p]) model_regs[wa[p]] = wd[p];
        if (pc_write) model_regs[15] = pc_update;
        if (cspr_write) model_cspr = cspr_update;
    endfunction

    task automatic check_all(input string tag);
        check_eq({tag, ".out1"}, out_data_1, model_out[0]);
        check_eq({tag, ".out2"}, out_data_2, model_out[1]);
        check_eq({tag, ".out3"}, out_data_3, model_out[2]);
        check_eq({tag, ".out4"}, out_data_4, model_regs[dbg_addr]);
        check_eq({tag, ".pc"},   pc,         model_regs[15]);
        check_eq({tag, ".cspr"}, cspr,       model_cspr);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (ack) model_commit();
        #1;
        n_step++;
        $display("[%0t] %s #%0d ack=%0b we=%b re=%b pcw=%0b csw=%0b pc=0x%08h",
                 $time, tag, n_step, ack, we, re, pc_write, cspr_write, pc);
        check_all(tag);
    endtask

    task automatic async_reset_pulse(input string tag);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        n_compared = 0; n_mismatched = 0; n_step = 0;
        drive_idle();
        dbg_addr = 4'd0;
        rst_n = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Write R0 then R1, read both back.
        we[0] = 1'b1; wa[0] = 4'd0; wd[0] = 32'h2;
        step("w_r0");
        drive_idle();
        we[1] = 1'b1; wa[1] = 4'd1; wd[1] = 32'h2;
        step("w_r1");
        drive_idle();
        re = 3'b011; ra[0] = 4'd0; ra[1] = 4'd1;
        step("rd_r0_r1");
        check_eq("rd_r0_r1.const1", out_data_1, 32'h2);
        check_eq("rd_r0_r1.const2", out_data_2, 32'h2);

        // Port 3 write/read loop on R2.
        for (int i = 0; i < 29; i++) begin
            drive_idle();
            we[2] = 1'b1; wa[2] = 4'd2; wd[2] = 32'h4 + 32'(i);
            step("p3_wr");
            drive_idle();
            re[2] = 1'b1; ra[2] = 4'd2;
            step("p3_rd");
            check_eq("p3_rd.const", out_data_3, 32'h4 + 32'(i));
        end

        // Port collision on R3 plus a distinct write to R5.
        drive_idle();
        we = 4'b1011;
        wa[0] = 4'd3; wd[0] = 32'h11;
        wa[3] = 4'd3; wd[3] = 32'h44;
        wa[1] = 4'd5; wd[1] = 32'h55;
        step("collide");
        drive_idle();
        dbg_addr = 4'd3; #1 check_eq("collide.r3", out_data_4, 32'h44);
        dbg_addr = 4'd5; #1 check_eq("collide.r5", out_data_4, 32'h55);

        // PC load beats port write to R15; CSPR load.
        we[0] = 1'b1; wa[0] = 4'd15; wd[0] = 32'h10;
        pc_write = 1'b1; pc_update = 32'h100;
        cspr_write = 1'b1; cspr_update = 32'hF000_0000;
        step("pc_cspr");
        check_eq("pc_cspr.pc", pc, 32'h100);
        check_eq("pc_cspr.cspr", cspr, 32'hF000_0000);
        dbg_addr = 4'd15; #1 check_eq("pc_cspr.r15", out_data_4, 32'h100);

        // ack low with everything enabled must freeze all state.
        drive_idle();
        ack = 1'b0;
        we = 4'hF; re = 3'h7; pc_write = 1'b1; cspr_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wa[i] = 4'(i + 6); wd[i] = $urandom;
        end
        for (int i = 0; i < 3; i++) ra[i] = 4'(i + 3);
        pc_update = $urandom; cspr_update = $urandom;
        repeat (3) step("ack_low");
        drive_idle();
        we[1] = 1'b1; wa[1] = 4'd6; wd[1] = 32'hABCD;
        re[1] = 1'b1; ra[1] = 4'd6;
        step("rbw");
        check_eq("rbw.old", out_data_2, 32'h0);
        drive_idle();
        re[1] = 1'b1; ra[1] = 4'd6;
        step("rbw_new");
        check_eq("rbw_new.val", out_data_2, 32'hABCD);

        // Asynchronous reset between edges.
        drive_idle();
        we[0] = 1'b1; wa[0] = 4'd4; wd[0] = 32'hDEAD_BEEF;
        step("w_r4");
        dbg_addr = 4'd4; #1 check_eq("w_r4.val", out_data_4, 32'hDEAD_BEEF);
        async_reset_pulse("arst");
        check_eq("arst.r4", out_data_4, 32'h0);
        check_eq("arst.pc", pc, 32'h0);
        check_eq("arst.cspr", cspr, 32'h0);

        // Randomized traffic with occasional mid-cycle resets.
        for (int k = 0; k < 400; k++) begin
            drive_idle();
            ack = ($urandom_range(0, 3) != 0);
            req = 1'($urandom);
            we = 4'($urandom);
            re = 3'($urandom);
            for (int i = 0; i < 4; i++) begin
                wa[i] = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
                wd[i] = $urandom;
            end
            for (int i = 0; i < 3; i++) ra[i] = 4'($urandom_range(0, 15));
            pc_write = ($urandom_range(0, 4) == 0);
            pc_update = $urandom;
            cspr_write = ($urandom_range(0, 4) == 0);
            cspr_update = $urandom;
            dbg_addr = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) async_reset_pulse("rand_arst");
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
